// File: rtl/riscv_pkg.sv
// Shared RV32M divider definitions: op encodings, divider FSM state encoding
// and the funct3 -> divider op mapping used by the decoder.
package riscv_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // The low two funct3 bits of the M-extension divide group line up with div_op_e.
  function automatic div_op_e funct3_to_div_op(input logic [2:0] f3);
    return div_op_e'(f3[1:0]);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  always_comb begin
    q_bit   = ({rem_in, quo_msb} >= {2'b00, divisor});
    rem_out = q_bit ? (WIDTH+1)'({rem_in, quo_msb} - {2'b00, divisor})
                    : (WIDTH+1)'({rem_in, quo_msb});
  end

endmodule

// File: rtl/divider_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// with a sign-fix cycle and single-cycle handling of divide-by-zero and overflow.
module divider_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output div_state_e       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: start is a request that is taken only in IDLE (busy=0); once taken,
  // a/b/op are ignored until done, a one-cycle pulse with result valid alongside it.
  div_state_e       state_q, state_d;
  div_op_e          op_q;
  logic [WIDTH-1:0] quo_q, div_q, result_q;
  logic [WIDTH:0]   rem_q;
  logic             a_neg_q, b_neg_q;
  logic [CW-1:0]    cnt_q;

  logic             is_signed, a_neg, b_neg, div_zero, overflow, special;
  logic [WIDTH-1:0] a_mag, b_mag, special_res, fix_res;
  logic [WIDTH:0]   step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_msb (quo_q[WIDTH-1]),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    div_zero  = (b == '0);
    overflow  = is_signed && (a == MIN_NEG) && (b == '1);
    special   = div_zero | overflow;
    if (div_zero) special_res = op[1] ? a : '1;
    else          special_res = op[1] ? '0 : a;
  end

  // Signed results are rebuilt from the unsigned magnitudes computed in CALC.
  always_comb begin
    fix_res = quo_q;
    case (op_q)
      DIV_OP_DIV:  fix_res = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
      DIV_OP_DIVU: fix_res = quo_q;
      DIV_OP_REM:  fix_res = a_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      DIV_OP_REMU: fix_res = rem_q[WIDTH-1:0];
      default:     fix_res = quo_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= DIV_OP_DIV;
      quo_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          op_q    <= div_op_e'(op);
          quo_q   <= a_mag;
          div_q   <= b_mag;
          rem_q   <= '0;
          a_neg_q <= a_neg;
          b_neg_q <= b_neg;
          cnt_q   <= CW'(WIDTH);
          if (special) result_q <= special_res;
        end
        CALC: if (cnt_q != '0) begin
          rem_q <= step_rem;
          quo_q <= {quo_q[WIDTH-2:0], step_bit};
          cnt_q <= cnt_q - 1'b1;
        end
        FIX:     result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed vectors, hand-written corner
// sequences and a randomized sweep against an arithmetic reference model.
module tb_divider_unit;
  import riscv_pkg::*;

  localparam int W = 32;
  localparam int NORMAL_LAT = W + 2;
  localparam int SPECIAL_LAT = 0;
  localparam int MAX_WAIT = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] result;
  div_state_e   dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  divider_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_div(input logic [1:0] f_op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic signed [W-1:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 0) return (f_op[1]) ? x : {W{1'b1}};
    if (f_op == 2'b00 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
    if (f_op == 2'b10 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
    case (f_op)
      2'b00:   return sx / sy;
      2'b01:   return x / y;
      2'b10:   return sx % sy;
      default: return x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] f_op, input logic [W-1:0] x,
                                    input logic [W-1:0] y);
    return (y == 0) || (!f_op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [1:0] f_op, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op = f_op;
    a = x;
    b = y;
    exp_q.push_back(ref_div(f_op, x, y));
  endtask

  // Called #1 after the accepting edge; counts edges until done is seen.
  task automatic wait_done(input bit noisy, output int lat);
    lat = 0;
    while (!done && lat < MAX_WAIT) begin
      if (noisy) begin
        start = lat[0];
        op = 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 32'(lat), 32'(MAX_WAIT) + 1);
  endtask

  task automatic score(input string name, input int lat, input int exp_lat);
    logic [W-1:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({name, "_result"}, result, exp);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy_at_done"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic do_op(input string name, input logic [1:0] f_op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int exp_lat);
    int lat;
    launch(f_op, x, y);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_done(1'b0, lat);
    score(name, lat, exp_lat);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    string      name;
    logic [1:0] f_op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    int k;
    logic [1:0] r_op;
    logic [W-1:0] r_a, r_b;

    vecs[0] = '{"divu_100_7",  2'b01, 32'd100,      32'd7,          32'd14,         NORMAL_LAT};
    vecs[1] = '{"remu_100_7",  2'b11, 32'd100,      32'd7,          32'd2,          NORMAL_LAT};
    vecs[2] = '{"div_m100_7",  2'b00, -32'sd100,    32'd7,          32'hFFFF_FFF2,  NORMAL_LAT};
    vecs[3] = '{"rem_m100_7",  2'b10, -32'sd100,    32'd7,          32'hFFFF_FFFE,  NORMAL_LAT};
    vecs[4] = '{"div_by_zero", 2'b00, 32'd7,        32'd0,          32'hFFFF_FFFF,  SPECIAL_LAT};
    vecs[5] = '{"rem_by_zero", 2'b10, 32'd7,        32'd0,          32'd7,          SPECIAL_LAT};
    vecs[6] = '{"div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  SPECIAL_LAT};
    vecs[7] = '{"rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          SPECIAL_LAT};
    vecs[8] = '{"divu_max_1",  2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF,  NORMAL_LAT};
    vecs[9] = '{"div_7_m2",    2'b00, 32'd7,        32'hFFFF_FFFE,  32'hFFFF_FFFD,  NORMAL_LAT};

    // reset state
    #12;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state", {30'b0, dbg_state}, {30'b0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven directed vectors; expectations also cross-checked with the model
    for (int i = 0; i < 10; i++) begin
      check({vecs[i].name, "_model"}, ref_div(vecs[i].f_op, vecs[i].x, vecs[i].y), vecs[i].exp);
      do_op(vecs[i].name, vecs[i].f_op, vecs[i].x, vecs[i].y, vecs[i].lat);
    end

    // start pulses with junk operands while busy, then start held during the done cycle
    launch(2'b01, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    wait_done(1'b1, lat);
    score("busy_ignore", lat, NORMAL_LAT);
    start = 1'b1;
    op = 2'b11;
    a = 32'd100;
    b = 32'd7;
    exp_q.push_back(ref_div(2'b11, 32'd100, 32'd7));
    @(posedge clk);
    #1;
    check("start_at_done_ignored_busy", {31'b0, busy}, 32'd0);
    check("start_at_done_ignored_done", {31'b0, done}, 32'd0);
    check("result_held_after_done", result, 32'd14);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("back_to_back_busy", {31'b0, busy}, 32'd1);
    wait_done(1'b0, lat);
    score("back_to_back", lat, NORMAL_LAT);
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of CALC
    launch(2'b00, -32'sd100, 32'd7);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_state", {30'b0, dbg_state}, {30'b0, CALC});
    #2;
    rst_n = 1'b0;
    #1;
    check("midop_reset_busy", {31'b0, busy}, 32'd0);
    check("midop_reset_done", {31'b0, done}, 32'd0);
    check("midop_reset_result", result, 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op("after_reset", 2'b00, -32'sd100, 32'd7, NORMAL_LAT);

    // randomized sweep
    for (int i = 0; i < 200; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a = $urandom;
      r_b = $urandom;
      k = $urandom_range(0, 7);
      case (k)
        0: r_b = 32'd1;
        1: r_a = 32'd0;
        2: r_a = (r_b == 0) ? 32'd0 : r_a % r_b;
        3: r_b = 32'($urandom_range(1, 20));
        4: r_b = 32'd0;
        5: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        6: r_b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op("random", r_op, r_a, r_b, is_special(r_op, r_a, r_b) ? SPECIAL_LAT : NORMAL_LAT);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
